branch_squash_arbiter: RTL and testbench

//  Sits directly downstream of the execute block's branch writeback ports. Each cycle takes up to
//  BRU_NUM resolved branches, keeps the oldest mispredict (ROB age order, wrap flag aware), and issues
//  one registered squash request to ROB/rename/FTQ with a stall handshake. Counts mispredicts for perf.

---
 rtl/branch_squash_arbiter_pkg.sv | 23 ++
 rtl/branch_squash_arbiter_oldest_select.sv | 31 +++
 rtl/branch_squash_arbiter.sv | 124 ++++++++++++
 tb/tb_branch_squash_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_squash_arbiter_pkg.sv
// Shared core definitions: ROB/FTQ index types and the wrap-aware ROB age comparator.
package core_define;

    localparam int unsigned BRU_NUM  = 2;
    localparam int unsigned ROB_SIZE = 64;
    localparam int unsigned FTQ_SIZE = 32;
    localparam int unsigned XLEN     = 64;
    localparam int unsigned ROB_W    = $clog2(ROB_SIZE);
    localparam int unsigned FTQ_W    = $clog2(FTQ_SIZE);

    typedef struct packed {
        logic             flag;
        logic [ROB_W-1:0] idx;
    } robIdx_t;

    typedef logic [FTQ_W-1:0] ftqIdx_t;

    // a is older than b; flags differ once the ROB pointer has wrapped between them
    function automatic logic rob_older(input robIdx_t a, input robIdx_t b);
        return (a.flag == b.flag) ? (a.idx < b.idx) : (a.idx > b.idx);
    endfunction

endpackage

// File: rtl/branch_squash_arbiter_oldest_select.sv
// Combinational pick of the oldest valid ROB index among N entries.
module oldest_select
    import core_define::*;
#(
    parameter  int unsigned N  = 2,
    parameter  int unsigned W  = $bits(robIdx_t),
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   vld_i,
    input  logic [N*W-1:0] key_i,
    output logic           vld_o,
    output logic [IW-1:0]  idx_o
);

    logic [W-1:0] best_key;

    always_comb begin
        vld_o    = 1'b0;
        idx_o    = '0;
        best_key = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vld_i[i] && (!vld_o ||
                rob_older(robIdx_t'(key_i[i*W +: W]), robIdx_t'(best_key)))) begin
                vld_o    = 1'b1;
                idx_o    = IW'(i);
                best_key = key_i[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/branch_squash_arbiter.sv
// Oldest-mispredict squash arbiter: one registered squash request with stall handshake,
// a squash shadow to drop wrong-path writebacks, and a saturating mispredict counter.
module branch_squash_arbiter #(
    parameter  int unsigned BRU_NUM  = core_define::BRU_NUM,
    parameter  int unsigned ROB_SIZE = core_define::ROB_SIZE,
    parameter  int unsigned FTQ_SIZE = core_define::FTQ_SIZE,
    parameter  int unsigned XLEN     = core_define::XLEN,
    localparam int unsigned RW       = $clog2(ROB_SIZE),
    localparam int unsigned FW       = $clog2(FTQ_SIZE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BRU_NUM-1:0]        i_brwb_vld,
    input  logic [BRU_NUM*(RW+1)-1:0] i_brwb_robIdx,
    input  logic [BRU_NUM-1:0]        i_brwb_mispred,
    input  logic [BRU_NUM*XLEN-1:0]   i_brwb_npc,
    input  logic [BRU_NUM*FW-1:0]     i_brwb_ftqIdx,
    input  logic                      i_flush,
    input  logic                      i_squash_stall,
    output logic                      o_squash_vld,
    output logic [RW:0]               o_squash_robIdx,
    output logic [XLEN-1:0]           o_squash_npc,
    output logic [FW-1:0]             o_squash_ftqIdx,
    output logic [31:0]               o_mispred_cnt
);
    import core_define::*;

    localparam int unsigned KW = RW + 1;
    localparam int unsigned IW = (BRU_NUM > 1) ? $clog2(BRU_NUM) : 1;

    logic [BRU_NUM-1:0] cand_vld;
    logic               c_vld;
    logic [IW-1:0]      c_idx;
    robIdx_t            c_rob;
    logic [XLEN-1:0]    c_npc;
    logic [FW-1:0]      c_ftq;
    logic               c_ok;
    logic               accept;

    logic            p_vld_q,  p_vld_d;
    robIdx_t         p_rob_q,  p_rob_d;
    logic [XLEN-1:0] p_npc_q,  p_npc_d;
    logic [FW-1:0]   p_ftq_q,  p_ftq_d;
    logic            sh_vld_q, sh_vld_d;
    robIdx_t         sh_rob_q, sh_rob_d;
    logic [31:0]     cnt_q,    cnt_d;

    assign cand_vld = i_brwb_vld & i_brwb_mispred;

    oldest_select #(
        .N (BRU_NUM),
        .W (KW)
    ) u_oldest_select (
        .vld_i (cand_vld),
        .key_i (i_brwb_robIdx),
        .vld_o (c_vld),
        .idx_o (c_idx)
    );

    assign c_rob = robIdx_t'(i_brwb_robIdx[c_idx*KW +: KW]);
    assign c_npc = i_brwb_npc[c_idx*XLEN +: XLEN];
    assign c_ftq = i_brwb_ftqIdx[c_idx*FW +: FW];

    // Anything not older than the pending or last-issued squash is already on the wrong path
    assign c_ok   = c_vld
                 && (!p_vld_q  || rob_older(c_rob, p_rob_q))
                 && (!sh_vld_q || rob_older(c_rob, sh_rob_q));
    assign accept = p_vld_q && !i_squash_stall;

    always_comb begin
        p_vld_d  = p_vld_q;
        p_rob_d  = p_rob_q;
        p_npc_d  = p_npc_q;
        p_ftq_d  = p_ftq_q;
        sh_vld_d = sh_vld_q;
        sh_rob_d = sh_rob_q;
        cnt_d    = cnt_q;
        if (i_flush) begin
            p_vld_d  = 1'b0;
            sh_vld_d = 1'b0;
        end else begin
            if (accept) begin
                sh_vld_d = 1'b1;
                sh_rob_d = p_rob_q;
                cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
            end
            if (c_ok) begin
                p_vld_d = 1'b1;
                p_rob_d = c_rob;
                p_npc_d = c_npc;
                p_ftq_d = c_ftq;
            end else if (accept) begin
                p_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_vld_q  <= 1'b0;
            p_rob_q  <= '0;
            p_npc_q  <= '0;
            p_ftq_q  <= '0;
            sh_vld_q <= 1'b0;
            sh_rob_q <= '0;
            cnt_q    <= '0;
        end else begin
            p_vld_q  <= p_vld_d;
            p_rob_q  <= p_rob_d;
            p_npc_q  <= p_npc_d;
            p_ftq_q  <= p_ftq_d;
            sh_vld_q <= sh_vld_d;
            sh_rob_q <= sh_rob_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_squash_vld    = p_vld_q;
    assign o_squash_robIdx = p_rob_q;
    assign o_squash_npc    = p_npc_q;
    assign o_squash_ftqIdx = p_ftq_q;
    assign o_mispred_cnt   = cnt_q;

endmodule

// File: tb/tb_branch_squash_arbiter.sv
// Directed + randomized bench for branch_squash_arbiter against a ring-distance age model.
module tb_branch_squash_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   vld, mispred;
    logic [13:0]  rob;
    logic [127:0] npc;
    logic [9:0]   ftq;
    logic         flush, stall;
    logic         o_vld;
    logic [6:0]   o_rob;
    logic [63:0]  o_npc;
    logic [4:0]   o_ftq;
    logic [31:0]  o_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // reference state
    logic        m_pv, m_sv;
    logic [6:0]  m_prob, m_srob;
    logic [63:0] m_pnpc;
    logic [4:0]  m_pftq;
    logic [31:0] m_cnt;

    branch_squash_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .i_brwb_vld      (vld),
        .i_brwb_robIdx   (rob),
        .i_brwb_mispred  (mispred),
        .i_brwb_npc      (npc),
        .i_brwb_ftqIdx   (ftq),
        .i_flush         (flush),
        .i_squash_stall  (stall),
        .o_squash_vld    (o_vld),
        .o_squash_robIdx (o_rob),
        .o_squash_npc    (o_npc),
        .o_squash_ftqIdx (o_ftq),
        .o_mispred_cnt   (o_cnt)
    );

    always #5 clk = ~clk;

    // ROB indices live on a 128-position ring; a is older when b lies ahead by less than half
    function automatic bit m_older(input logic [6:0] a, input logic [6:0] b);
        logic [6:0] d;
        d = a - b;
        return d[6];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit          found;
        logic [6:0]  best_rob, r, old_prob;
        logic [63:0] best_npc;
        logic [4:0]  best_ftq;
        bit          acc;
        found    = 0;
        best_rob = '0;
        best_npc = '0;
        best_ftq = '0;
        acc      = m_pv && !stall;
        old_prob = m_prob;
        if (rst) begin
            m_pv = 0; m_sv = 0; m_prob = '0; m_srob = '0;
            m_pnpc = '0; m_pftq = '0; m_cnt = '0;
        end else if (flush) begin
            m_pv = 0;
            m_sv = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                r = rob[p*7 +: 7];
                if (vld[p] && mispred[p]
                    && (!m_pv || m_older(r, m_prob))
                    && (!m_sv || m_older(r, m_srob))
                    && (!found || m_older(r, best_rob))) begin
                    found    = 1;
                    best_rob = r;
                    best_npc = npc[p*64 +: 64];
                    best_ftq = ftq[p*5 +: 5];
                end
            end
            if (acc) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                m_sv   = 1;
                m_srob = old_prob;
            end
            if (found) begin
                m_pv = 1; m_prob = best_rob; m_pnpc = best_npc; m_pftq = best_ftq;
            end else if (acc) begin
                m_pv = 0;
            end
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        chk({tag, "_vld"}, o_vld, m_pv);
        chk({tag, "_rob"}, o_rob, m_prob);
        chk({tag, "_npc"}, o_npc, m_pnpc);
        chk({tag, "_ftq"}, o_ftq, m_pftq);
        chk({tag, "_cnt"}, o_cnt, m_cnt);
    endtask

    task automatic idle();
        vld = '0; mispred = '0; flush = 0; stall = 0;
    endtask

    task automatic set_port(input int p, input logic m, input logic [6:0] r,
                            input logic [63:0] n, input logic [4:0] f);
        vld[p]         = 1'b1;
        mispred[p]     = m;
        rob[p*7 +: 7]  = r;
        npc[p*64 +: 64] = n;
        ftq[p*5 +: 5]  = f;
    endtask

    task automatic do_flush();
        idle();
        flush = 1;
        tick("flush");
        flush = 0;
    endtask

    initial begin
        logic [31:0] cnt_ref;
        logic [6:0]  base;
        int unsigned off0, off1;

        rob = '0; npc = '0; ftq = '0;
        idle();
        rst = 1;
        m_pv = 0; m_sv = 0; m_prob = '0; m_srob = '0; m_pnpc = '0; m_pftq = '0; m_cnt = '0;
        #2;
        tick("rst0");
        tick("rst1");
        chk("rst_vld", o_vld, 1'b0);
        chk("rst_cnt", o_cnt, 32'd0);
        rst = 0;

        // 1: reset while a stalled squash is pending
        set_port(0, 1, 7'd30, 64'h3000, 5'd1);
        stall = 1;
        tick("t1_load");
        chk("t1_pending", o_vld, 1'b1);
        vld = '0;
        rst = 1;
        tick("t1_rst");
        chk("t1_vld", o_vld, 1'b0);
        chk("t1_cnt", o_cnt, 32'd0);
        rst = 0;
        idle();

        // 2: two mispredicts same cycle, older one wins
        set_port(0, 1, 7'd10, 64'h1000, 5'd3);
        set_port(1, 1, 7'd5,  64'h2000, 5'd7);
        tick("t2_issue");
        chk("t2_vld", o_vld, 1'b1);
        chk("t2_rob", o_rob, 7'd5);
        chk("t2_npc", o_npc, 64'h2000);
        chk("t2_ftq", o_ftq, 5'd7);
        idle();
        tick("t2_after");
        chk("t2_cnt", o_cnt, 32'd1);
        chk("t2_vld_fall", o_vld, 1'b0);

        // 3: ROB wrap, {0,60} is older than {1,2}
        do_flush();
        set_port(0, 1, 7'b1_000010, 64'hA000, 5'd2);
        set_port(1, 1, 7'b0_111100, 64'hB000, 5'd4);
        tick("t3_issue");
        chk("t3_rob", o_rob, 7'b0_111100);
        chk("t3_npc", o_npc, 64'hB000);
        idle();
        tick("t3_after");

        // 4: stalled pending replaced by older, younger ignored, one accept
        do_flush();
        cnt_ref = o_cnt;
        stall = 1;
        set_port(0, 1, 7'd20, 64'h2020, 5'd9);
        tick("t4_c1");
        vld = '0;
        tick("t4_c2");
        set_port(0, 1, 7'd15, 64'h1515, 5'd10);
        tick("t4_c3");
        chk("t4_switch", o_rob, 7'd15);
        set_port(0, 1, 7'd25, 64'h2525, 5'd11);
        tick("t4_c4");
        chk("t4_keep", o_rob, 7'd15);
        chk("t4_stall_vld", o_vld, 1'b1);
        idle();
        tick("t4_acc");
        chk("t4_cnt", o_cnt, cnt_ref + 32'd1);
        chk("t4_vld_fall", o_vld, 1'b0);

        // 5: shadow of the accepted {0,20}
        do_flush();
        set_port(0, 1, 7'd20, 64'h2020, 5'd9);
        tick("t5_load");
        idle();
        tick("t5_acc");
        set_port(0, 1, 7'd22, 64'h2222, 5'd12);
        tick("t5_young");
        chk("t5_young_vld", o_vld, 1'b0);
        set_port(0, 1, 7'd18, 64'h1818, 5'd13);
        tick("t5_old");
        chk("t5_old_vld", o_vld, 1'b1);
        chk("t5_old_rob", o_rob, 7'd18);
        idle();
        tick("t5_after");

        // 6: flush overrides pending and same-cycle mispredict
        do_flush();
        set_port(0, 1, 7'd40, 64'h4040, 5'd14);
        stall = 1;
        tick("t6_load");
        cnt_ref = o_cnt;
        set_port(0, 1, 7'd35, 64'h3535, 5'd15);
        stall = 0;
        flush = 1;
        tick("t6_flush");
        chk("t6_vld", o_vld, 1'b0);
        chk("t6_cnt", o_cnt, cnt_ref);
        idle();
        tick("t6_after");
        chk("t6_vld_after", o_vld, 1'b0);

        // random: indices kept in a sliding window so every pair has a defined age
        base = 7'd100;
        for (int k = 0; k < 400; k++) begin
            flush   = (k % 20 == 0) || ($urandom % 32 == 0);
            base    = base + 7'($urandom % 2);
            stall   = ($urandom % 3 == 0);
            off0    = $urandom % 32;
            off1    = $urandom % 32;
            if (off1 == off0) off1 = (off1 + 1) % 32;
            vld     = 2'($urandom);
            mispred = {($urandom % 3 != 0), ($urandom % 3 != 0)};
            rob     = {base + 7'(off1), base + 7'(off0)};
            npc     = {$urandom, $urandom, $urandom, $urandom};
            ftq     = 10'($urandom);
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
